// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and frame payload for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND,
    WAIT_TX,
    WAIT_BUSY
  } state_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
  } frame_t;

  function automatic logic is_known_cmd(input logic [7:0] c);
    return (c == CMD_WR) || (c == CMD_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_regfile.sv
// Small 8-bit register file with single write port and a flat read bus.
module uart_cmd_regfile
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [7:0]            wdata_i,
  output logic [NUM_REGS*8-1:0] rdata_o
);

  logic [7:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 8'h00;
    end else if (we_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (waddr_i == ADDR_W'(i)) regs_q[i] <= wdata_i;
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_rd
    assign rdata_o[8*g +: 8] = regs_q[g];
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses host write/read frames from uart_rx, accesses the register file and
// launches exactly one response byte per completed frame towards uart_tx.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic [NUM_REGS*8-1:0] reg_bus,
  output logic                  cmd_done,
  output logic                  err_timeout,
  output logic                  err_drop
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  frame_t              frame_q, frame_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                cmd_done_q, cmd_done_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_drop_q, err_drop_d;
  logic                we_c;
  logic                addr_ok_c;
  logic [7:0]          rd_byte_c;

  uart_cmd_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_c),
    .waddr_i (addr_q),
    .wdata_i (frame_q.data),
    .rdata_o (reg_bus)
  );

  assign addr_ok_c = ({1'b0, addr_q} < NUM_REGS_W);

  // Read mux over the implemented registers only.
  always_comb begin
    rd_byte_c = 8'h00;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (addr_q == ADDR_W'(i)) rd_byte_c = reg_bus[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      cmd_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      cmd_done_q    <= cmd_done_d;
      err_timeout_q <= err_timeout_d;
      err_drop_q    <= err_drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    cmd_done_d    = 1'b0;
    err_timeout_d = err_timeout_q;
    err_drop_d    = err_drop_q;
    we_c          = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_valid) begin
          frame_d.cmd = rx_data;
          state_d     = is_known_cmd(rx_data) ? GET_ADDR : EXEC;
        end
      end
      GET_ADDR: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = (frame_q.cmd == CMD_WR) ? GET_DATA : EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          frame_d.data = rx_data;
          cnt_d        = '0;
          state_d      = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXEC: begin
        if (!is_known_cmd(frame_q.cmd) || !addr_ok_c) begin
          tx_data_d = RSP_NAK;
        end else if (frame_q.cmd == CMD_WR) begin
          we_c      = 1'b1;
          tx_data_d = RSP_ACK;
        end else begin
          tx_data_d = rd_byte_c;
        end
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          cmd_done_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX:   state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Bytes arriving while a response is in flight are discarded.
    if (rx_valid && (state_q inside {EXEC, SEND, WAIT_TX, WAIT_BUSY})) err_drop_d = 1'b1;
  end

  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign cmd_done    = cmd_done_q;
  assign err_timeout = err_timeout_q;
  assign err_drop    = err_drop_q;

endmodule
